// File: rtl/chan_mux_rr_if.sv
// Handshake bundle for chan_mux_rr: N valid/ready producers in, one registered valid/ready stream out.
// The slave modport is the multiplexer's view; the master modport is the producer/consumer side.
interface chan_mux_rr_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/chan_mux_rr.sv
// Registered N-channel multiplexer with valid/ready on every input and the output.
// Passes one selected channel (mode=0) or scans all channels with a round-robin grant (mode=1).
module chan_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic            clk,
    input  logic            rst,
    chan_mux_rr_if.slave    bus
);

    logic [SEL_W-1:0]    r_ptr;
    logic [SEL_W-1:0]    r_out_ch;
    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_valid;

    logic                w_load;
    logic                w_any;
    logic [CHANNELS-1:0] w_grant;
    logic [SEL_W-1:0]    w_idx;
    logic [WIDTH-1:0]    w_data;
    int                  w_cand;

    assign w_load = ~r_out_valid | bus.out_ready;

    // Grant search: fixed mode matches sel exactly, round-robin walks ptr+1 onward with wrap.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_data  = '0;
        w_any   = 1'b0;
        w_cand  = 0;
        if (!bus.mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                    w_grant[i] = 1'b1;
                    w_idx      = SEL_W'(i);
                    w_data     = bus.in_data[i*WIDTH +: WIDTH];
                    w_any      = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                w_cand = (int'(r_ptr) + k) % CHANNELS;
                if (!w_any && bus.in_valid[w_cand]) begin
                    w_grant[w_cand] = 1'b1;
                    w_idx           = SEL_W'(w_cand);
                    w_data          = bus.in_data[w_cand*WIDTH +: WIDTH];
                    w_any           = 1'b1;
                end
            end
        end
    end

    assign bus.in_ready = rst ? '0 : (w_grant & {CHANNELS{w_load}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= SEL_W'(CHANNELS - 1);
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_ch    <= w_idx;
                if (bus.mode) begin
                    r_ptr <= w_idx;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed bench for chan_mux_rr: 8-bit/4-channel main instance plus a 16-bit/3-channel edge instance.
// Expected output words are queued when a transfer is expected and popped one cycle later.
module tb_chan_mux_rr;

    logic clk;
    logic rst;

    chan_mux_rr_if #(.WIDTH(8),  .CHANNELS(4), .SEL_W(2)) ifa ();
    chan_mux_rr_if #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) ifb ();

    chan_mux_rr #(.WIDTH(8),  .CHANNELS(4), .SEL_W(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    chan_mux_rr #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int n_assert;
    int n_fail;
    logic [9:0] sb_q [$];
    logic [7:0] last_d;
    logic [1:0] last_ch;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, asserts=%0d", n_assert);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on instance A: check in_ready, optionally queue the expected word, clock, check result.
    task automatic cyc(input string tag, input logic [3:0] exp_rdy, input bit push,
                       input logic [7:0] d, input logic [1:0] ch, input logic exp_vld);
        logic [9:0] w;
        #1;
        chk({tag, ".in_ready"}, 32'(ifa.in_ready), 32'(exp_rdy));
        if (push) sb_q.push_back({d, ch});
        tick();
        chk({tag, ".out_valid"}, 32'(ifa.out_valid), 32'(exp_vld));
        if (push) begin
            w       = sb_q.pop_front();
            last_d  = w[9:2];
            last_ch = w[1:0];
        end
        chk({tag, ".out_data"}, 32'(ifa.out_data), 32'(last_d));
        chk({tag, ".out_ch"},   32'(ifa.out_ch),   32'(last_ch));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        last_d   = 8'd0;
        last_ch  = 2'd0;
        rst      = 1'b1;
        ifa.in_data   = {8'd9, 8'd4, 8'd8, 8'd14};
        ifa.in_valid  = 4'b1111;
        ifa.mode      = 1'b1;
        ifa.sel       = 2'd0;
        ifa.out_ready = 1'b1;
        ifb.in_data   = {16'h0F0F, 16'hABCD, 16'h1234};
        ifb.in_valid  = 3'b000;
        ifb.mode      = 1'b0;
        ifb.sel       = 2'd0;
        ifb.out_ready = 1'b1;

        // Reset state with traffic offered
        #1;
        chk("rst.in_ready", 32'(ifa.in_ready), 32'h0);
        chk("rst.out_valid", 32'(ifa.out_valid), 32'h0);
        tick();
        chk("rst.hold_valid", 32'(ifa.out_valid), 32'h0);
        chk("rst.hold_data", 32'(ifa.out_data), 32'h0);
        chk("rst.hold_in_ready", 32'(ifa.in_ready), 32'h0);
        rst = 1'b0;

        // Fixed-mode sweep
        ifa.mode = 1'b0;
        ifa.sel = 2'd0; cyc("fix0", 4'b0001, 1, 8'd14, 2'd0, 1'b1);
        ifa.sel = 2'd1; cyc("fix1", 4'b0010, 1, 8'd8,  2'd1, 1'b1);
        ifa.sel = 2'd2; cyc("fix2", 4'b0100, 1, 8'd4,  2'd2, 1'b1);
        ifa.sel = 2'd3; cyc("fix3", 4'b1000, 1, 8'd9,  2'd3, 1'b1);

        // Round-robin fairness: pointer untouched by fixed mode, so search starts at 0
        ifa.mode = 1'b1;
        for (int r = 0; r < 2; r++) begin
            cyc("rr0", 4'b0001, 1, 8'd14, 2'd0, 1'b1);
            cyc("rr1", 4'b0010, 1, 8'd8,  2'd1, 1'b1);
            cyc("rr2", 4'b0100, 1, 8'd4,  2'd2, 1'b1);
            cyc("rr3", 4'b1000, 1, 8'd9,  2'd3, 1'b1);
        end

        // Round-robin skip over idle channels 0 and 2
        ifa.in_valid = 4'b1010;
        for (int r = 0; r < 2; r++) begin
            cyc("skip1", 4'b0010, 1, 8'd8, 2'd1, 1'b1);
            cyc("skip3", 4'b1000, 1, 8'd9, 2'd3, 1'b1);
        end

        // Back-pressure holding the word from channel 1
        ifa.in_valid = 4'b1111;
        cyc("bp_pre0", 4'b0001, 1, 8'd14, 2'd0, 1'b1);
        cyc("bp_pre1", 4'b0010, 1, 8'd8,  2'd1, 1'b1);
        ifa.out_ready = 1'b0;
        for (int r = 0; r < 3; r++) cyc("bp_hold", 4'b0000, 0, 8'd0, 2'd0, 1'b1);
        ifa.out_ready = 1'b1;
        cyc("bp_release", 4'b0100, 1, 8'd4, 2'd2, 1'b1);

        // Asynchronous reset between edges while a word is held
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out_valid", 32'(ifa.out_valid), 32'h0);
        chk("arst.out_data", 32'(ifa.out_data), 32'h0);
        chk("arst.out_ch", 32'(ifa.out_ch), 32'h0);
        chk("arst.in_ready", 32'(ifa.in_ready), 32'h0);
        tick();
        chk("arst.edge_in_ready", 32'(ifa.in_ready), 32'h0);
        chk("arst.edge_out_valid", 32'(ifa.out_valid), 32'h0);
        rst = 1'b0;
        last_d  = 8'd0;
        last_ch = 2'd0;
        cyc("post_rst", 4'b0001, 1, 8'd14, 2'd0, 1'b1);

        // Drain: no requests, valid drops while data/ch hold
        ifa.in_valid = 4'b0000;
        cyc("drain", 4'b0000, 0, 8'd0, 2'd0, 1'b0);

        // Instance B: WIDTH=16, CHANNELS=3, out-of-range select
        ifb.in_valid  = 3'b111;
        ifb.sel       = 2'd1;
        ifb.out_ready = 1'b0;
        #1;
        chk("b.sel1_ready", 32'(ifb.in_ready), 32'h2);
        tick();
        chk("b.load_valid", 32'(ifb.out_valid), 32'h1);
        chk("b.load_data", 32'(ifb.out_data), 32'hABCD);
        chk("b.load_ch", 32'(ifb.out_ch), 32'h1);
        ifb.sel = 2'd3;
        #1;
        chk("b.sel3_bp_ready", 32'(ifb.in_ready), 32'h0);
        tick();
        chk("b.bp_valid", 32'(ifb.out_valid), 32'h1);
        chk("b.bp_data", 32'(ifb.out_data), 32'hABCD);
        ifb.out_ready = 1'b1;
        #1;
        chk("b.sel3_ready", 32'(ifb.in_ready), 32'h0);
        tick();
        chk("b.pop_valid", 32'(ifb.out_valid), 32'h0);
        chk("b.pop_data_hold", 32'(ifb.out_data), 32'hABCD);
        chk("b.pop_ch_hold", 32'(ifb.out_ch), 32'h1);
        tick();
        chk("b.idle_valid", 32'(ifb.out_valid), 32'h0);
        chk("b.idle_ready", 32'(ifb.in_ready), 32'h0);

        chk("sb.empty", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_mux_rr.md
# chan_mux_rr

Parametrised, registered N-channel multiplexer with valid/ready handshakes on every input and on the output. It either passes one software-selected channel (fixed mode) or scans all channels with a fair round-robin grant (round-robin mode). It replaces the combinational four-to-one 8-bit multiplexer wherever several producers share one consumer, such as score, piece and line-clear data feeding a single display/ALU path. It adds output buffering, back-pressure and fairness, which the combinational part lacks.

## Interface
- WIDTH, 8, data bits per channel
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, select/channel-index width, equal to ceil(log2(CHANNELS))

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  CHANNELS*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  per-channel request
- in_ready  out  CHANNELS  per-channel accept; combinational, one-hot or zero
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SEL_W  channel index used in fixed mode; values ≥ CHANNELS select no channel
- out_data  out  WIDTH  registered data
- out_ch  out  SEL_W  registered index of the channel that supplied out_data
- out_valid  out  1  registered output valid
- out_ready  in  1  consumer accept

## Operation
- Load enable: `load = ~out_valid | out_ready`. The output register accepts a new word only when `load` is 1.
- Grant, fixed mode: `grant = onehot(sel)` if `sel < CHANNELS` and `in_valid[sel]`, otherwise 0. Other channels are never granted, even when they are valid.
- Grant, round-robin mode: the search starts at `ptr+1` and wraps modulo CHANNELS. The first channel with valid asserted is granted.
- `in_ready = grant & {CHANNELS{load}}`. A transfer occurs on channel i when `in_valid[i] & in_ready[i]`.
- On a transfer: `out_data <= in_data[i]`, `out_ch <= i`, `out_valid <= 1`.
  - In round-robin mode, `ptr <= i`.
  - In fixed mode, ptr holds its value.
- When `load` is 1 and there is no grant: `out_valid <= 0`. out_data and out_ch hold their values.
- When `load` is 0: all output registers hold, and in_ready is all-zero.
- Mode or sel changes take effect in the same cycle's grant. A word already in the output register is unaffected.
- Fairness: in round-robin mode with all channels continuously valid and out_ready high, grants rotate 0,1,…,CHANNELS-1,0. No channel waits more than CHANNELS-1 transfers.

## Timing
- Reset values (asynchronous, held while rst is high): out_valid=0, out_data=0, out_ch=0, ptr=CHANNELS-1. As a result, the first round-robin search starts at channel 0.
- While rst is high, in_ready is forced to 0.
- Latency: 1 cycle from an input transfer edge to out_valid/out_data.
- Throughput: 1 word per cycle when out_ready is held high.
- Simultaneous pop and push in the same cycle (out_valid=1, out_ready=1, and a granted input valid): the register is replaced with no bubble.
- Back-pressure: while out_valid=1 and out_ready=0, out_data, out_ch and out_valid are stable, and no input is accepted.
- Reset mid-transfer: a word present in the output register is discarded. After rst deasserts, operation resumes on the first rising edge.
- Pointer wrap: after ptr=CHANNELS-1, the search order is 0,1,….
- An input must hold in_data stable while in_valid=1 and in_ready=0. The block does not check this.

## Test plan
- Reset check: assert rst asynchronously between clock edges mid-stream. Required: out_valid=0, out_data=0, out_ch=0 immediately, and in_ready=0 while rst is high. The first round-robin grant after release goes to channel 0.
- Fixed-mode sweep: CHANNELS=4, WIDTH=8, inputs 14, 8, 4, 9, all valid, out_ready=1. Step sel through 0,1,2,3, one per cycle. Required: out_data is 14, 8, 4, 9 and out_ch is 0,1,2,3, each one cycle after its sel value. Only in_ready[sel] is asserted.
- Round-robin fairness: all four channels continuously valid with the same inputs, out_ready=1, mode=1, for 8 cycles. Required: out_ch sequence 0,1,2,3,0,1,2,3 and out_data sequence 14,8,4,9,14,8,4,9, with out_valid continuously high.
- Round-robin skip: only channels 1 and 3 valid, mode=1. Required: out_ch alternates 1,3,1,3. in_ready[0] and in_ready[2] are never asserted.
- Back-pressure: hold out_ready=0 for 3 cycles while out_valid=1 with out_data=8. Required: out_data stays 8, in_ready is all-zero, and ptr is unchanged. When out_ready rises, the next channel is loaded in that same cycle's edge.
- Parameter and edge case: WIDTH=16, CHANNELS=3, mode=0, sel=3 (out of range) with all inputs valid. Required: no grant, and out_valid falls to 0 after the pending word is popped.
